// File: rtl/celement_pipe_n.sv
// N-stage clocked Muller C-element pipeline with a two-phase handshake at both ends.
// Each stage can wait a programmable number of enabled cycles before it fires, and the ack back to the predecessor can be delayed.
module celement_pipe_n #(
  parameter int               DEPTH      = 4,
  parameter logic [DEPTH-1:0] INIT_STATE = '0,
  parameter int               SEND_DLY   = 0,
  parameter int               ACK_DLY    = 0,
  parameter int               DLY_W      = 4,
  parameter int               SYNC       = 0
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             SENDIN,
  input  logic             ACKIN,
  input  logic             LOPEN,
  output logic             SENDOUT,
  output logic             ACKOUT,
  output logic [DEPTH-1:0] CP,
  output logic [DEPTH-1:0] STATE
);

  localparam logic [DLY_W-1:0] SEND_DLY_C = DLY_W'(SEND_DLY);

  logic             send_s;
  logic             ack_s;
  logic [DEPTH-1:0] c_q, c_d;
  logic [DEPTH-1:0] cp_q, cp_d;
  logic [DLY_W-1:0] cnt_q [DEPTH];
  logic [DLY_W-1:0] cnt_d [DEPTH];
  logic [DEPTH-1:0] p, n, en, ready;

  generate
    if (SYNC != 0) begin : g_sync
      logic [1:0] send_sync_q;
      logic [1:0] ack_sync_q;
      always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
          send_sync_q <= '0;
          ack_sync_q  <= '0;
        end else begin
          send_sync_q <= {send_sync_q[0], SENDIN};
          ack_sync_q  <= {ack_sync_q[0], ACKIN};
        end
      end
      assign send_s = send_sync_q[1];
      assign ack_s  = ack_sync_q[1];
    end else begin : g_nosync
      assign send_s = SENDIN;
      assign ack_s  = ACKIN;
    end
  endgenerate

  // Stage i sees its predecessor's output on p and its successor's output on n.
  // The two ends of the chain see the external request and acknowledge instead.
  assign p  = {c_q[DEPTH-2:0], send_s};
  assign n  = {ack_s, c_q[DEPTH-1:1]};
  assign en = (p ^ n) & (c_q ^ p);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (SEND_DLY == 0) begin : g_nodly
        assign ready[gi] = 1'b1;
      end else begin : g_dly
        assign ready[gi] = (cnt_q[gi] >= SEND_DLY_C);
      end
    end
  endgenerate

  always_comb begin
    c_d  = c_q;
    cp_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (LOPEN) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!en[i]) begin
          cnt_d[i] = '0;
        end else if (!ready[i]) begin
          cnt_d[i] = cnt_q[i] + DLY_W'(1);
        end else begin
          c_d[i]   = p[i];
          cnt_d[i] = '0;
          cp_d[i]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      c_q  <= INIT_STATE;
      cp_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      c_q  <= c_d;
      cp_q <= cp_d;
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  generate
    if (ACK_DLY == 0) begin : g_ack_direct
      assign ACKOUT = c_q[0];
    end else begin : g_ack_chain
      logic [ACK_DLY-1:0] ack_dly_q;
      logic [ACK_DLY-1:0] ack_dly_d;
      // Shift left with c[0] entering at bit 0; the top bit falls off the truncating cast.
      assign ack_dly_d = ACK_DLY'({ack_dly_q, c_q[0]});
      always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
          ack_dly_q <= {ACK_DLY{INIT_STATE[0]}};
        end else begin
          ack_dly_q <= ack_dly_d;
        end
      end
      assign ACKOUT = ack_dly_q[ACK_DLY-1];
    end
  endgenerate

  assign SENDOUT = c_q[DEPTH-1];
  assign STATE   = c_q;
  assign CP      = cp_q;

endmodule
